// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: MULT/MULTU/DIV/DIVU at one result bit per cycle.
// HI/LO are architectural registers, also writable directly via MTHI/MTLO while idle.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        neg32 = ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        neg64 = ~v + 64'd1;
    endfunction

    // Shift-add step: acc = {partial product, remaining multiplier bits}.
    function automatic logic [63:0] mul_step(input logic [63:0] acc,
                                             input logic [31:0] mcand);
        logic [32:0] sum;
        if (acc[0]) begin
            sum = {1'b0, acc[63:32]} + {1'b0, mcand};
        end else begin
            sum = {1'b0, acc[63:32]};
        end
        mul_step = {sum, acc[31:1]};
    endfunction

    // Restoring step: acc = {remainder, dividend bits shifting out / quotient bits in}.
    function automatic logic [63:0] div_step(input logic [63:0] acc,
                                             input logic [31:0] dsor);
        logic [32:0] shifted;
        logic        fits;
        logic [31:0] diff;
        shifted = {acc[63:32], acc[31]};
        fits    = (shifted >= {1'b0, dsor});
        diff    = shifted[31:0] - dsor;
        if (fits) begin
            div_step = {diff, acc[30:0], 1'b1};
        end else begin
            div_step = {shifted[31:0], acc[30:0], 1'b0};
        end
    endfunction

    state_t      state_r;
    logic [1:0]  op_r;
    logic        sa_r;
    logic        sb_r;
    logic        bzero_r;
    logic [31:0] a_orig_r;
    logic [31:0] opnd_r;
    logic [63:0] acc_r;
    logic [5:0]  cnt_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        is_signed_s;
    logic        is_mul_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [63:0] step_s;
    logic [31:0] fix_hi_s;
    logic [31:0] fix_lo_s;
    logic [63:0] prod_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    // Operand magnitudes for the start latch; signed ops work on |a| and |b|.
    always_comb begin
        is_signed_s = ~op[0];
        is_mul_s    = ~op[1];
        if (is_signed_s && a[31]) begin
            a_mag_s = neg32(a);
        end else begin
            a_mag_s = a;
        end
        if (is_signed_s && b[31]) begin
            b_mag_s = neg32(b);
        end else begin
            b_mag_s = b;
        end
    end

    // One iteration of whichever algorithm is in flight.
    always_comb begin
        if (!op_r[1]) begin
            step_s = mul_step(acc_r, opnd_r);
        end else begin
            step_s = div_step(acc_r, opnd_r);
        end
    end

    // Sign correction and HI/LO selection applied in the FIX cycle.
    always_comb begin
        prod_s   = acc_r;
        quot_s   = acc_r[31:0];
        rem_s    = acc_r[63:32];
        fix_hi_s = hi_r;
        fix_lo_s = lo_r;
        case (op_r)
            OP_MULT: begin
                if (sa_r ^ sb_r) begin
                    prod_s = neg64(acc_r);
                end else begin
                    prod_s = acc_r;
                end
                fix_hi_s = prod_s[63:32];
                fix_lo_s = prod_s[31:0];
            end
            OP_MULTU: begin
                fix_hi_s = acc_r[63:32];
                fix_lo_s = acc_r[31:0];
            end
            OP_DIV: begin
                if (sa_r ^ sb_r) begin
                    quot_s = neg32(acc_r[31:0]);
                end else begin
                    quot_s = acc_r[31:0];
                end
                if (sa_r) begin
                    rem_s = neg32(acc_r[63:32]);
                end else begin
                    rem_s = acc_r[63:32];
                end
                if (bzero_r) begin
                    fix_hi_s = a_orig_r;
                    fix_lo_s = 32'hFFFF_FFFF;
                end else begin
                    fix_hi_s = rem_s;
                    fix_lo_s = quot_s;
                end
            end
            OP_DIVU: begin
                if (bzero_r) begin
                    fix_hi_s = a_orig_r;
                    fix_lo_s = 32'hFFFF_FFFF;
                end else begin
                    fix_hi_s = acc_r[63:32];
                    fix_lo_s = acc_r[31:0];
                end
            end
            default: begin
                fix_hi_s = hi_r;
                fix_lo_s = lo_r;
            end
        endcase
    end

    // Control FSM with operand latch, iteration datapath and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            op_r     <= 2'b00;
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
            bzero_r  <= 1'b0;
            a_orig_r <= 32'd0;
            opnd_r   <= 32'd0;
            acc_r    <= 64'd0;
            cnt_r    <= 6'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r     <= op;
                        sa_r     <= is_signed_s & a[31];
                        sb_r     <= is_signed_s & b[31];
                        bzero_r  <= (b == 32'd0);
                        a_orig_r <= a;
                        cnt_r    <= 6'd0;
                        busy_r   <= 1'b1;
                        state_r  <= ST_ITER;
                        // Multiply keeps the multiplier in acc; divide keeps the dividend.
                        if (is_mul_s) begin
                            opnd_r <= a_mag_s;
                            acc_r  <= {32'd0, b_mag_s};
                        end else begin
                            opnd_r <= b_mag_s;
                            acc_r  <= {32'd0, a_mag_s};
                        end
                    end else begin
                        if (hi_we) begin
                            hi_r <= wd;
                        end
                        if (lo_we) begin
                            lo_r <= wd;
                        end
                    end
                end
                ST_ITER: begin
                    acc_r <= step_s;
                    cnt_r <= cnt_r + 6'd1;
                    if (cnt_r == 6'd31) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_r    <= fix_hi_s;
                    lo_r    <= fix_lo_s;
                    cnt_r   <= 6'd0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    cnt_r   <= 6'd0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: constant vector table, modelled random ops, and hold/abort sequences.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        poke;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    int   checks;
    int   failures;
    exp_t sb_q[$];
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Independent arithmetic reference for random operands.
    function automatic exp_t model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        exp_t r;
        logic signed [63:0] sa, sbv, q, rm;
        logic [63:0] p;
        sa  = {{32{ma[31]}}, ma};
        sbv = {{32{mb[31]}}, mb};
        case (mop)
            2'b00: begin p = sa * sbv; r.hi = p[63:32]; r.lo = p[31:0]; end
            2'b01: begin p = {32'd0, ma} * {32'd0, mb}; r.hi = p[63:32]; r.lo = p[31:0]; end
            2'b10: begin
                if (mb == 32'd0) begin r.hi = ma; r.lo = 32'hFFFF_FFFF; end
                else begin q = sa / sbv; rm = sa % sbv; r.hi = rm[31:0]; r.lo = q[31:0]; end
            end
            default: begin
                if (mb == 32'd0) begin r.hi = ma; r.lo = 32'hFFFF_FFFF; end
                else begin r.hi = ma % mb; r.lo = ma / mb; end
            end
        endcase
        return r;
    endfunction

    // Called at a negedge with the unit idle (or in its done cycle); returns at the done negedge.
    task automatic do_op(input string nm, input logic [1:0] vop, input logic [31:0] va,
                         input logic [31:0] vb, input exp_t e, input logic poke);
        int   cyc;
        exp_t got;
        start = 1'b1; op = vop; a = va; b = vb;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (done) check({nm, "_done_while_busy"}, 64'(done), 64'd0);
            if (poke && cyc == 10) begin
                start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2;
                hi_we = 1'b1; lo_we = 1'b1; wd = 32'h1234_5678;
            end
            @(negedge clk);
            if (poke && cyc == 10) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
                check({nm, "_hold_hi"}, 64'(hi), 64'(cur_hi));
                check({nm, "_hold_lo"}, 64'(lo), 64'(cur_lo));
            end
        end
        check({nm, "_busy_cycles"}, 64'(cyc), 64'd33);
        check({nm, "_done"}, 64'(done), 64'd1);
        if (sb_q.size() == 0) begin
            check({nm, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            got = sb_q.pop_front();
            check({nm, "_hi"}, 64'(hi), 64'(got.hi));
            check({nm, "_lo"}, 64'(lo), 64'(got.lo));
            cur_hi = got.hi;
            cur_lo = got.lo;
        end
    endtask

    vec_t vecs[8];

    initial begin
        int   ncyc;
        exp_t e;
        checks = 0; failures = 0;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wd = 32'd0;
        cur_hi = 32'd0; cur_lo = 32'd0;

        vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[4] = '{2'b11, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b0};
        vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        vecs[6] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{2'b00, 32'd6,         32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFE8, 1'b1};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        // Back-to-back: each op after the first is launched during the previous done cycle.
        for (int i = 0; i < 8; i++) begin
            e.hi = vecs[i].hi; e.lo = vecs[i].lo;
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, e, vecs[i].poke);
        end
        @(negedge clk);
        check("done_single_pulse", 64'(done), 64'd0);

        for (int i = 0; i < 6; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 5) ? 32'd0 : $urandom;
            do_op($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb), 1'b0);
        end
        @(negedge clk);

        // MTHI/MTLO writes in IDLE, separately and together.
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'h5A5A_A5A5;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mt_both_hi", 64'(hi), 64'h5A5A_A5A5);
        check("mt_both_lo", 64'(lo), 64'h5A5A_A5A5);
        hi_we = 1'b1; wd = 32'hAAAA_5555;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wd = 32'h0F0F_0F0F;
        check("mthi", 64'(hi), 64'hAAAA_5555);
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo", 64'(lo), 64'h0F0F_0F0F);
        check("mthi_kept", 64'(hi), 64'hAAAA_5555);

        // Start wins over a simultaneous MTHI/MTLO.
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check("start_wins_hi", 64'(hi), 64'hAAAA_5555);
        check("start_wins_lo", 64'(lo), 64'h0F0F_0F0F);
        check("start_busy", 64'(busy), 64'd1);
        repeat (8) @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2;
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'h1111_2222;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check("busy_hold_hi", 64'(hi), 64'hAAAA_5555);
        check("busy_hold_lo", 64'(lo), 64'h0F0F_0F0F);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ncyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) ncyc++;
        end
        check("abort_no_done", 64'(ncyc), 64'd0);
        check("abort_hi_after", 64'(hi), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS execute stage, beside the ALU. It consumes the two register-file read operands (rs, rt) and performs MULT, MULTU, DIV and DIVU over multiple cycles, one result bit per cycle. Results go into internal HI/LO registers, which feed the MFHI/MFLO writeback mux. While an operation is in flight, the unit drives `busy` so the hazard logic can stall dependent instructions.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` input 1: single clock; all state changes on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `start` input 1: launch operation; sampled only when `busy`=0.
- `op` input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `a` input 32: rs operand (multiplicand / dividend); sampled with `start`.
- `b` input 32: rt operand (multiplier / divisor); sampled with `start`.
- `hi_we` input 1: MTHI strobe; writes `wd` into HI.
- `lo_we` input 1: MTLO strobe; writes `wd` into LO.
- `wd` input 32: MTHI/MTLO data.
- `busy` output 1: operation in flight.
- `done` output 1: one-cycle pulse; HI/LO updated this cycle.
- `hi` output 32: HI register, registered output.
- `lo` output 32: LO register, registered output.

## Operation
- States: IDLE, ITER, FIX.
- IDLE, `start`=1:
  - Latch `op`.
  - Signed ops latch |a| and |b|, plus sign flags sa and sb; unsigned ops latch a and b raw.
  - Clear the 6-bit iteration counter.
  - Go to ITER.
- ITER, multiply: radix-2 shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- ITER, divide: restoring division, one quotient bit per cycle, MSB first. The 33-bit trial subtract is rem − divisor; the quotient bit is the inverted borrow.
- Counter increments each ITER cycle. After the 32nd ITER cycle (counter = 31), go to FIX.
- FIX: sign correction, then the HI/LO write.
  - MULT: if sa^sb, negate the 64-bit product (two's complement). HI = product[63:32], LO = product[31:0].
  - DIV: if sa^sb, negate the quotient; if sa, negate the remainder. LO = quotient, HI = remainder.
  - Unsigned ops: no correction.
- FIX then returns to IDLE, with `done` pulsing during the following cycle.
- Divide by zero (b=0 latched), DIV or DIVU:
  - LO = 32'hFFFFFFFF, HI = original `a`.
  - No sign correction.
  - Same latency as a normal divide.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This is the natural result of the magnitude path and needs no special case.
- MTHI/MTLO:
  - In IDLE, `hi_we` writes HI and `lo_we` writes LO at the clock edge. Both may assert in the same cycle.
  - Ignored while `busy`=1.
  - Ignored in any cycle where `start` is accepted; the start wins.
- `start` while `busy`=1: ignored. Operands are not re-latched and the in-flight operation is unaffected.
- HI/LO hold their value during ITER and FIX; they change only at the FIX→IDLE edge, or on an IDLE MTHI/MTLO write.
- Reset, including mid-operation: abort, state = IDLE, counter = 0, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0.

## Timing
- Start accepted at edge E0; `busy` = 1 from just after E0.
- ITER occupies edges E1–E32; FIX is entered at E32.
- At edge E33:
  - HI/LO are written and the state returns to IDLE.
  - `busy` = 0 and `done` = 1 for exactly the cycle between E33 and E34.
- Latency start-edge to result: 33 cycles, fixed for all ops and operands (no early termination).
- A new `start` may be accepted at E33's following edge (E34), i.e. during the `done` cycle. That `done` cycle is IDLE.
- `busy` and `done` are registered, with no combinational path from inputs.
- `hi` and `lo` are driven directly from flops.

## Test plan
- Reset, then idle for 5 cycles → `hi` = `lo` = 0, `busy` = `done` = 0.
- MULT a=0xFFFFFFFD (−3), b=7 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; `done` is a single pulse and `busy` was high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2.
- DIVU a=0x12345678, b=0 → lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Combined hold/abort check:
  - MTHI 0xAAAA5555 and MTLO 0x0F0F0F0F in IDLE → registers update next edge.
  - Then start MULTU 3×5. Assert `start` (2×2), `hi_we` and `lo_we` at cycle 10 → all ignored; hi/lo still 0xAAAA5555 / 0x0F0F0F0F.
  - Assert `reset` at cycle 20 → `busy` = 0 and hi = lo = 0 immediately; no `done` pulse follows.
